// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB slave register block returning Simulink data to the PowerPC.
// Software arms a one-shot capture of user_data_in, polls status, reads the
// frozen snapshot, and can inspect a saturating capture counter and a sticky
// overflow flag. User logic and the OPB side share OPB_Clk.
`timescale 1ns/1ps
module opb_register_simulink2ppc_snap #(
   parameter logic [31:0] C_BASEADDR   = 32'h010B2300,
   parameter logic [31:0] C_HIGHADDR   = 32'h010B23FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex5"
) (
   input  logic                        OPB_Clk,
   input  logic                        OPB_Rst_n,
   input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
   input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
   input  logic                        OPB_RNW,
   input  logic                        OPB_select,
   input  logic                        OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
   output logic                        Sl_xferAck,
   output logic                        Sl_errAck,
   output logic                        Sl_retry,
   output logic                        Sl_toutSup,
   input  logic [31:0]                 user_data_in,
   input  logic                        user_valid,
   output logic                        user_armed
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_RECOV} state_t;

   localparam logic [5:0] IDX_DATA = 6'd0;
   localparam logic [5:0] IDX_CTRL = 6'd1;
   localparam logic [5:0] IDX_LIVE = 6'd2;

   state_t      state_reg, state_next;
   logic [31:0] rdata_reg;
   logic [31:0] snap_reg;
   logic        armed_reg;
   logic        valid_reg;
   logic        ovf_reg;
   logic [15:0] count_reg;

   logic        hit;
   logic        latch_en;
   logic [5:0]  reg_idx;
   logic [31:0] wdata;
   logic        wr_ctrl;
   logic        arm_wr;
   logic        clr_ovf_wr;
   logic        clr_cnt_wr;
   logic        rd_data_lat;
   logic        capture;
   logic        overflow_evt;
   logic [31:0] rd_mux;
   logic        unused_ok;

   // Address decode and the one-cycle bus events derived from it
   assign hit         = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign latch_en    = (state_reg == ST_IDLE) && hit;
   assign reg_idx     = OPB_ABus[24:29];
   assign wdata       = 32'(OPB_DBus);
   assign wr_ctrl     = latch_en && !OPB_RNW && OPB_BE[C_OPB_DWIDTH/8-1] && (reg_idx == IDX_CTRL);
   assign arm_wr      = wr_ctrl && wdata[0];
   assign clr_ovf_wr  = wr_ctrl && wdata[2];
   assign clr_cnt_wr  = wr_ctrl && wdata[3];
   assign rd_data_lat = latch_en && OPB_RNW && (reg_idx == IDX_DATA);

   // An arm write landing with user_valid defers the capture to a later strobe
   assign capture      = armed_reg && user_valid && !arm_wr;
   assign overflow_evt = user_valid && !armed_reg && valid_reg;

   // Bits that carry no function here are folded together to keep lint quiet
   assign unused_ok = ^{OPB_seqAddr, OPB_BE, wdata, (C_FAMILY == "virtex5")};

   // Read-data multiplexer, sampled into rdata_reg at the latch cycle
   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         IDX_DATA: rd_mux = snap_reg;
         IDX_CTRL: rd_mux = {count_reg, 13'd0, ovf_reg, valid_reg, armed_reg};
         IDX_LIVE: rd_mux = user_data_in;
         default:  rd_mux = '0;
      endcase
   end

   // Bus FSM state register
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Bus FSM next state: accept, acknowledge, then one recovery cycle
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (hit) state_next = ST_ACK;
         ST_ACK:   state_next = ST_RECOV;
         ST_RECOV: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Bus FSM outputs: data bus is driven only while acknowledging
   always_comb begin
      Sl_xferAck = (state_reg == ST_ACK);
      Sl_DBus    = Sl_xferAck ? C_OPB_DWIDTH'(rdata_reg) : '0;
      Sl_errAck  = 1'b0;
      Sl_retry   = 1'b0;
      Sl_toutSup = 1'b0;
      user_armed = armed_reg;
   end

   // Read latch, capture engine and status bits
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         rdata_reg <= '0;
         snap_reg  <= '0;
         armed_reg <= 1'b0;
         valid_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         if (latch_en) begin
            rdata_reg <= rd_mux;
         end

         if (arm_wr) begin
            armed_reg <= 1'b1;
         end else if (capture) begin
            armed_reg <= 1'b0;
         end

         // A capture on the same edge as a DATA read leaves valid set
         if (capture) begin
            valid_reg <= 1'b1;
         end else if (rd_data_lat) begin
            valid_reg <= 1'b0;
         end

         // Overflow set wins over a simultaneous software clear
         if (overflow_evt) begin
            ovf_reg <= 1'b1;
         end else if (clr_ovf_wr) begin
            ovf_reg <= 1'b0;
         end

         // Software clear wins over a simultaneous capture increment
         if (clr_cnt_wr) begin
            count_reg <= '0;
         end else if (capture && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
         end

         if (capture) begin
            snap_reg <= user_data_in;
         end
      end
   end

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Self-checking bench for opb_register_simulink2ppc_snap: directed scenarios
// with literal expectations followed by randomized bus/user traffic, all
// compared every cycle against a behavioural model of the register block.
`timescale 1ns/1ps
module tb_opb_register_simulink2ppc_snap;

   localparam logic [31:0] BASE = 32'h010B2300;
   localparam logic [31:0] HIGH = 32'h010B23FF;
   localparam logic [31:0] A_DATA = BASE + 32'h0;
   localparam logic [31:0] A_CTRL = BASE + 32'h4;
   localparam logic [31:0] A_LIVE = BASE + 32'h8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [0:31] abus = '0;
   logic [0:3]  be = '0;
   logic [0:31] dbus = '0;
   logic        rnw = 1'b0;
   logic        sel = 1'b0;
   logic        seqaddr = 1'b0;
   logic [0:31] sl_dbus;
   logic        ack, errack, retry, toutsup;
   logic [31:0] udi = '0;
   logic        uvalid = 1'b0;
   logic        uarmed;

   int n_checks = 0;
   int n_fail   = 0;

   opb_register_simulink2ppc_snap dut (
      .OPB_Clk     (clk),
      .OPB_Rst_n   (rst_n),
      .OPB_ABus    (abus),
      .OPB_BE      (be),
      .OPB_DBus    (dbus),
      .OPB_RNW     (rnw),
      .OPB_select  (sel),
      .OPB_seqAddr (seqaddr),
      .Sl_DBus     (sl_dbus),
      .Sl_xferAck  (ack),
      .Sl_errAck   (errack),
      .Sl_retry    (retry),
      .Sl_toutSup  (toutsup),
      .user_data_in(udi),
      .user_valid  (uvalid),
      .user_armed  (uarmed)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_snap = '0;
   logic        m_armed = 1'b0;
   logic        m_valid = 1'b0;
   logic        m_ovf = 1'b0;
   logic [15:0] m_count = '0;
   logic [31:0] m_rd = '0;
   logic        exp_ack = 1'b0;
   int          m_busy = 0;   // cycles still owed to the current transfer

   always @(posedge clk or negedge rst_n) begin
      logic [31:0] a, w;
      int          word;
      bit          do_arm, do_clr_ovf, do_clr_cnt, do_rd_data, cap, ov;
      if (!rst_n) begin
         m_snap = '0; m_armed = 0; m_valid = 0; m_ovf = 0; m_count = '0;
         m_rd = '0; exp_ack = 0; m_busy = 0;
      end else begin
         do_arm = 0; do_clr_ovf = 0; do_clr_cnt = 0; do_rd_data = 0;
         a = abus;
         w = dbus;
         exp_ack = 0;
         if (m_busy > 0) begin
            m_busy = m_busy - 1;
         end else if (sel && a >= BASE && a <= HIGH) begin
            word = int'((a - BASE) >> 2);
            case (word)
               0: m_rd = m_snap;
               1: m_rd = (32'(m_count) << 16) | (32'(m_ovf) << 2) | (32'(m_valid) << 1) | 32'(m_armed);
               2: m_rd = udi;
               default: m_rd = 32'h0;
            endcase
            if (rnw && word == 0) do_rd_data = 1;
            if (!rnw && be[3] && word == 1) begin
               do_arm     = w[0];
               do_clr_ovf = w[2];
               do_clr_cnt = w[3];
            end
            exp_ack = 1;
            m_busy  = 2;
         end
         cap = m_armed && uvalid && !do_arm;
         ov  = uvalid && !m_armed && m_valid;
         if (cap) m_snap = udi;
         if (do_clr_cnt) m_count = 0;
         else if (cap && m_count != 16'hFFFF) m_count = m_count + 1;
         m_ovf   = ov ? 1'b1 : (do_clr_ovf ? 1'b0 : m_ovf);
         m_valid = cap ? 1'b1 : (do_rd_data ? 1'b0 : m_valid);
         m_armed = do_arm ? 1'b1 : (cap ? 1'b0 : m_armed);
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      check32("ack", 32'(ack), 32'(exp_ack));
      check32("dbus", sl_dbus, exp_ack ? m_rd : 32'h0);
      check32("user_armed", 32'(uarmed), 32'(m_armed));
      check32("tieoffs", 32'({errack, retry, toutsup}), 32'h0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic xfer(input logic [31:0] addr, input bit rd_nwr, input logic [31:0] wd,
                       input logic [3:0] be_v, input bit uv, input logic [31:0] ud,
                       output logic [31:0] rd, output bit acked);
      @(posedge clk); #1;
      sel = 1; abus = addr; rnw = rd_nwr; dbus = wd; be = be_v;
      uvalid = uv;
      if (uv) udi = ud;
      @(posedge clk); #1;
      uvalid = 0;
      @(negedge clk);
      acked = ack;
      rd    = sl_dbus;
      @(posedge clk); #1;
      sel = 0; abus = '0; dbus = '0; be = '0; rnw = 0;
   endtask

   task automatic expect_rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] rd;
      bit          acked;
      xfer(addr, 1, 32'h0, 4'hF, 0, 32'h0, rd, acked);
      check32(name, rd, exp);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
      logic [31:0] rd;
      bit          acked;
      xfer(addr, 0, wd, 4'hF, 0, 32'h0, rd, acked);
   endtask

   task automatic pulse(input logic [31:0] d);
      @(posedge clk); #1;
      uvalid = 1; udi = d;
      @(posedge clk); #1;
      uvalid = 0;
   endtask

   initial begin
      logic [31:0] rd, addr, wd;
      bit          acked;
      int          op;

      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1;

      // Reset state
      expect_rd("reset_ctrl", A_CTRL, 32'h00000000);
      expect_rd("reset_data", A_DATA, 32'h00000000);

      // Arm then capture, overflow, clear overflow
      wr(A_CTRL, 32'h1);
      pulse(32'hDEADBEEF);
      expect_rd("cap_ctrl", A_CTRL, 32'h00010002);
      pulse(32'h0BADF00D);
      expect_rd("ovf_ctrl", A_CTRL, 32'h00010006);
      wr(A_CTRL, 32'h4);
      expect_rd("ovf_clr_ctrl", A_CTRL, 32'h00010002);
      expect_rd("cap_data", A_DATA, 32'hDEADBEEF);
      expect_rd("valid_clr_ctrl", A_CTRL, 32'h00010000);

      // Reset asserted during the acknowledge cycle
      @(posedge clk); #1;
      sel = 1; abus = A_CTRL; rnw = 1; be = 4'hF;
      @(posedge clk); #1;
      check32("ack_pre_reset", 32'(ack), 32'h1);
      #1 rst_n = 0;
      #1 check32("ack_drop_on_reset", 32'(ack), 32'h0);
      sel = 0; abus = '0; rnw = 0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      expect_rd("post_reset_ctrl", A_CTRL, 32'h00000000);
      expect_rd("post_reset_data", A_DATA, 32'h00000000);

      // Arm write coincident with user_valid: no capture, armed afterwards
      xfer(A_CTRL, 0, 32'h1, 4'hF, 1, 32'h12345678, rd, acked);
      expect_rd("arm_sim_ctrl", A_CTRL, 32'h00000001);
      expect_rd("arm_sim_data", A_DATA, 32'h00000000);
      pulse(32'hA5A5A5A5);
      expect_rd("arm_sim_cap", A_DATA, 32'hA5A5A5A5);

      // Capture coincident with a DATA read: old data returned, valid stays
      wr(A_CTRL, 32'h1);
      xfer(A_DATA, 1, 32'h0, 4'hF, 1, 32'h77777777, rd, acked);
      check32("rd_vs_cap_data", rd, 32'hA5A5A5A5);
      expect_rd("rd_vs_cap_ctrl", A_CTRL, 32'h00020002);

      // Clear-ovf coincident with an overflow event: ovf stays set
      xfer(A_CTRL, 0, 32'h4, 4'hF, 1, 32'h55555555, rd, acked);
      expect_rd("clrovf_vs_ovf", A_CTRL, 32'h00020006);
      wr(A_CTRL, 32'h4);

      // Writes to read-only offsets and writes without BE[3] have no effect
      wr(A_DATA, 32'hFFFFFFFF);
      xfer(A_CTRL, 0, 32'h1, 4'b1110, 0, 32'h0, rd, acked);
      check32("be3_low_acked", 32'(acked), 32'h1);
      expect_rd("ro_write_data", A_DATA, 32'h77777777);

      // Bus timing on LIVE, and an out-of-window address
      udi = 32'h0000CAFE;
      xfer(A_LIVE, 1, 32'h0, 4'hF, 0, 32'h0, rd, acked);
      check32("live_ack", 32'(acked), 32'h1);
      check32("live_data", rd, 32'h0000CAFE);
      xfer(32'h010B2400, 1, 32'h0, 4'hF, 0, 32'h0, rd, acked);
      check32("miss_no_ack", 32'(acked), 32'h0);
      expect_rd("unused_off", BASE + 32'h40, 32'h00000000);

      // Counter saturation: preload near the top instead of 65k captures
      @(negedge clk);
      force dut.count_reg = 16'hFFFD;
      m_count = 16'hFFFD;
      #1 release dut.count_reg;
      for (int i = 0; i < 3; i++) begin
         wr(A_CTRL, 32'h1);
         pulse(32'h1000 + 32'(i));
      end
      expect_rd("sat_ctrl", A_CTRL, 32'hFFFF0002);
      wr(A_CTRL, 32'h1);
      xfer(A_CTRL, 0, 32'h8, 4'hF, 1, 32'hBEEF0001, rd, acked);
      expect_rd("clrcnt_vs_cap", A_CTRL, 32'h00000002);
      expect_rd("clrcnt_data", A_DATA, 32'hBEEF0001);

      // Randomized traffic, checked every cycle by the compare process
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 5);
         case ($urandom_range(0, 7))
            0:       addr = 32'h010B2400;
            1:       addr = BASE - 32'h4;
            2:       addr = BASE + 32'hFC;
            default: addr = BASE + 32'(4 * $urandom_range(0, 3));
         endcase
         wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15));
         if (op <= 2) begin
            xfer(addr, $urandom_range(0, 1) == 1, wd,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                 $urandom_range(0, 1) == 1, $urandom, rd, acked);
         end else if (op <= 4) begin
            pulse($urandom);
         end else begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
         end
      end
      expect_rd("final_ctrl_model", A_CTRL,
                (32'(m_count) << 16) | (32'(m_ovf) << 2) | (32'(m_valid) << 1) | 32'(m_armed));

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
